// File: rtl/rca_bist.sv
// rca_bist: built-in self-test wrapper for an external combinational
// ripple-carry adder. A 16-bit Fibonacci LFSR produces operand pairs for
// a_o/b_o. The returned sum s_i is compared with an internal reference.
// The block counts checked vectors and mismatches, then reports pass/fail.
// Optional build macro BIST_ERR_LOG_EN adds a log of the first mismatching
// vector of each run. This log is exposed on err_seen/err_a/err_b/err_s.
module rca_bist #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned NUM_VECTORS = 150,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH:0]   s_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      vec_count,
  output logic [15:0]      err_count
`ifdef BIST_ERR_LOG_EN
  ,
  output logic             err_seen,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [WIDTH:0]   err_s
`endif
);

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [15:0] LP_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LP_NUM  = 16'(NUM_VECTORS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_vec;
  logic [15:0]      r_err;

  logic             w_fb;
  logic [15:0]      w_lfsrNext;
  logic [WIDTH:0]   w_ref;
  logic             w_mismatch;
  logic [15:0]      w_vecNext;
  logic [15:0]      w_errNext;
  logic             w_lastVec;
  logic             w_errZeroAfter;

  // Next LFSR value, reference sum, and the updated counts for the CHECK step.
  always_comb begin
    w_fb           = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    w_lfsrNext     = {r_lfsr[14:0], w_fb};
    w_ref          = {1'b0, r_a} + {1'b0, r_b};
    w_mismatch     = (s_i != w_ref);
    w_vecNext      = r_vec + 16'd1;
    w_errNext      = (r_err == 16'hFFFF) ? r_err : (r_err + 16'd1);
    w_lastVec      = (w_vecNext == LP_NUM);
    w_errZeroAfter = (r_err == 16'd0) && !w_mismatch;
  end

  // Run sequencer: one DRIVE plus one CHECK cycle per vector, with registered status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= LP_SEED;
      r_a     <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_vec   <= 16'd0;
      r_err   <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_lfsr <= LP_SEED;
            r_vec  <= 16'd0;
            r_err  <= 16'd0;
            if (LP_NUM == 16'd0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= ST_DRIVE;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        ST_DRIVE: begin
          r_a     <= r_lfsr[WIDTH-1:0];
          r_b     <= r_lfsr[2*WIDTH-1:WIDTH];
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          r_vec  <= w_vecNext;
          r_lfsr <= w_lfsrNext;
          if (w_mismatch) begin
            r_err <= w_errNext;
          end
          if (w_lastVec) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_errZeroAfter;
          end else begin
            r_state <= ST_DRIVE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign a_o       = r_a;
  assign b_o       = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign vec_count = r_vec;
  assign err_count = r_err;

`ifdef BIST_ERR_LOG_EN
  logic             r_errSeen;
  logic [WIDTH-1:0] r_errA;
  logic [WIDTH-1:0] r_errB;
  logic [WIDTH:0]   r_errS;

  // Keep the first mismatching vector of a run; a new run start clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_errSeen <= 1'b0;
      r_errA    <= '0;
      r_errB    <= '0;
      r_errS    <= '0;
    end else if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
      r_errSeen <= 1'b0;
      r_errA    <= '0;
      r_errB    <= '0;
      r_errS    <= '0;
    end else if (r_state == ST_CHECK && w_mismatch && !r_errSeen) begin
      r_errSeen <= 1'b1;
      r_errA    <= r_a;
      r_errB    <= r_b;
      r_errS    <= s_i;
    end
  end

  assign err_seen = r_errSeen;
  assign err_a    = r_errA;
  assign err_b    = r_errB;
  assign err_s    = r_errS;
`endif

endmodule
